rv_mtimer: RTL

Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the core's data bus, downstream of the core's memory interface. Decodes loads and stores in its address window, keeps a free-running 64-bit counter behind a programmable prescaler, and drives the machine timer interrupt request to the core's CSR unit (mip.MTIP).

---
 rtl/rv_mtimer_pkg.sv | 40 ++++
 rtl/rv_mtimer_counter.sv | 46 ++++
 rtl/rv_mtimer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rv_mtimer_pkg.sv
// Shared definitions for the memory-mapped RISC-V machine timer:
// register offsets, CTRL field layout, reset constants and the byte-lane merge helper.
package rv_mtimer_pkg;

  localparam logic [4:0] OffMtimeLo = 5'h00;
  localparam logic [4:0] OffMtimeHi = 5'h04;
  localparam logic [4:0] OffCmpLo   = 5'h08;
  localparam logic [4:0] OffCmpHi   = 5'h0C;
  localparam logic [4:0] OffCtrl    = 5'h10;
  localparam logic [4:0] OffStatus  = 5'h14;

  localparam int CtrlEnBit  = 0;
  localparam int CtrlDivLsb = 8;

  localparam logic [63:0] MtimeReset    = 64'h0;
  localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    StIdle,
    StResp
  } acc_state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } acc_op_e;

  // Lanes with a clear enable keep the old byte.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newVal[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_mtimer_counter.sv
// Prescaler plus free-running 64-bit mtime counter with per-half software load ports.
// A load replaces one half and leaves the other at its pre-increment value (no carry).
module rv_mtimer_counter
  import rv_mtimer_pkg::*;
#(
  parameter int PrescaleWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [PrescaleWidth-1:0] div_i,
  input  logic                     clear_pre_i,
  input  logic                     load_lo_i,
  input  logic                     load_hi_i,
  input  logic [31:0]              load_data_i,
  output logic [63:0]              mtime_o
);

  logic [PrescaleWidth-1:0] pre_cnt_q, pre_cnt_d;
  logic [63:0]              mtime_q, mtime_d;
  logic                     tick;

  always_comb begin
    tick      = en_i && (pre_cnt_q == div_i);
    pre_cnt_d = pre_cnt_q + PrescaleWidth'(1);
    if (!en_i || clear_pre_i || tick) pre_cnt_d = '0;

    mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
    // Software load wins over a coincident tick on the whole word.
    if (load_lo_i) mtime_d = {mtime_q[63:32], load_data_i};
    if (load_hi_i) mtime_d = {load_data_i, mtime_q[31:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      mtime_q   <= MtimeReset;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      mtime_q   <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/rv_mtimer.sv
// RISC-V machine timer on the core data bus: access FSM, register file,
// 64-bit mtime >= mtimecmp compare and the registered MTIP request.
module rv_mtimer
  import rv_mtimer_pkg::*;
#(
  parameter int               Width         = 32,
  parameter logic [Width-1:0] BaseAddress   = 32'hFFFF_FF00,
  parameter int               PrescaleWidth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] address,
  input  logic             rd,
  input  logic             wr,
  input  logic [3:0]       byte_en,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] data_out,
  output logic             hit,
  output logic             complete_read,
  output logic             complete_write,
  output logic             mtip
);

  acc_state_e               state_q;
  acc_op_e                  op_q;
  logic [4:0]               off_q;
  logic [31:0]              wdata_q;
  logic [3:0]               be_q;
  logic                     ctrl_en_q;
  logic [PrescaleWidth-1:0] ctrl_div_q;
  logic [63:0]              mtimecmp_q;
  logic [31:0]              shadow_q;
  logic [Width-1:0]         rdata_q;
  logic                     complete_read_q;
  logic                     complete_write_q;
  logic                     mtip_q;

  logic [63:0] mtime;
  logic [31:0] ctrlWord;
  logic [31:0] rdata;
  logic        writeResp;
  logic        loadLo;
  logic        loadHi;
  logic        clearPre;
  logic [31:0] loadData;

  assign hit = (address[Width-1:5] == BaseAddress[Width-1:5]) && (address[1:0] == 2'b00);

  always_comb begin
    ctrlWord                              = '0;
    ctrlWord[CtrlEnBit]                   = ctrl_en_q;
    ctrlWord[CtrlDivLsb +: PrescaleWidth] = ctrl_div_q;

    rdata = '0;
    case (off_q)
      OffMtimeLo: rdata = mtime[31:0];
      OffMtimeHi: rdata = shadow_q;
      OffCmpLo:   rdata = mtimecmp_q[31:0];
      OffCmpHi:   rdata = mtimecmp_q[63:32];
      OffCtrl:    rdata = ctrlWord;
      OffStatus:  rdata = {31'b0, mtip_q};
      default:    rdata = '0;
    endcase
  end

  // The counter owns mtime, so writes to it are steered through load strobes in RESP.
  always_comb begin
    writeResp = (state_q == StResp) && (op_q == OpWrite);
    loadLo    = writeResp && (off_q == OffMtimeLo) && (|be_q);
    loadHi    = writeResp && (off_q == OffMtimeHi) && (|be_q);
    clearPre  = writeResp && (off_q == OffCtrl);
    loadData  = mergeBytes((off_q == OffMtimeHi) ? mtime[63:32] : mtime[31:0], wdata_q, be_q);
  end

  rv_mtimer_counter #(
    .PrescaleWidth(PrescaleWidth)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ctrl_en_q),
    .div_i      (ctrl_div_q),
    .clear_pre_i(clearPre),
    .load_lo_i  (loadLo),
    .load_hi_i  (loadHi),
    .load_data_i(loadData),
    .mtime_o    (mtime)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      op_q             <= OpRead;
      off_q            <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      ctrl_en_q        <= 1'b0;
      ctrl_div_q       <= '0;
      mtimecmp_q       <= MtimecmpReset;
      shadow_q         <= '0;
      rdata_q          <= '0;
      complete_read_q  <= 1'b0;
      complete_write_q <= 1'b0;
      mtip_q           <= 1'b0;
    end else begin
      complete_read_q  <= 1'b0;
      complete_write_q <= 1'b0;
      mtip_q           <= (mtime >= mtimecmp_q);

      case (state_q)
        StIdle: begin
          // A simultaneous rd and wr is treated as a read; the write is dropped.
          if ((rd || wr) && hit) begin
            state_q <= StResp;
            op_q    <= rd ? OpRead : OpWrite;
            off_q   <= address[4:0];
            wdata_q <= data_in[31:0];
            be_q    <= byte_en;
          end
        end

        StResp: begin
          state_q <= StIdle;
          if (op_q == OpRead) begin
            complete_read_q <= 1'b1;
            rdata_q         <= Width'(rdata);
            if (off_q == OffMtimeLo) shadow_q <= mtime[63:32];
          end else begin
            complete_write_q <= 1'b1;
            case (off_q)
              OffCmpLo: mtimecmp_q[31:0]  <= mergeBytes(mtimecmp_q[31:0], wdata_q, be_q);
              OffCmpHi: mtimecmp_q[63:32] <= mergeBytes(mtimecmp_q[63:32], wdata_q, be_q);
              OffCtrl: begin
                ctrl_en_q  <= mergeBytes(ctrlWord, wdata_q, be_q)[CtrlEnBit];
                ctrl_div_q <= mergeBytes(ctrlWord, wdata_q, be_q)[CtrlDivLsb +: PrescaleWidth];
              end
              default: ;
            endcase
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out       = rdata_q;
  assign complete_read  = complete_read_q;
  assign complete_write = complete_write_q;
  assign mtip           = mtip_q;

endmodule
